awg_cmd_decoder: RTL and testbench
==================================

# awg_cmd_decoder

Multi-channel, framed successor to the single-byte AWG control decoder. It parses checksummed UART command packets and writes per-channel waveform parameters into shadow registers. On a commit command, all shadow values are transferred to live outputs in the same cycle. It sits between the UART receiver and the per-channel waveform generators/DAC scaling path.

## Interface
- NUM_CH, 2: number of waveform channels (1–15)
- FREQ_W, 16: frequency word width (≤16)
- AMP_W, 10: amplitude width (≤16)
- OFF_W, 10: DC offset width (≤16)
- TIMEOUT_CYC, 100000: max idle cycles between bytes of one packet (≥2)
- clk  in  1  system clock, one clock domain
- rst_n  in  1  asynchronous, active-low reset
- uart_data  in  8  received byte
- data_valid  in  1  one-cycle strobe, uart_data valid
- waveform_type  out  2*NUM_CH  live waveform select, ch0 in LSBs
- frequency  out  FREQ_W*NUM_CH  live frequency words
- amplitude  out  AMP_W*NUM_CH  live amplitudes
- dc_offset  out  OFF_W*NUM_CH  live offsets
- update_stb  out  1  one-cycle pulse, live outputs just changed
- cmd_ok  out  1  one-cycle pulse, packet accepted
- cmd_err  out  1  one-cycle pulse, packet rejected/aborted
- err_code  out  3  cause of last error, held until next error

## Operation
- Packet: SYNC (0xA5), HDR {chan[7:4], reg[3:0]}, D_HI, D_LO, CHK. Payload = {D_HI, D_LO}.
- CHK must equal HDR ^ D_HI ^ D_LO.
- reg ids: 0 waveform, 1 frequency, 2 amplitude, 3 dc_offset, 0xF commit (chan and payload ignored). All other ids are invalid.
- chan 0xF = broadcast to all channels. Any other chan ≥ NUM_CH is invalid.
- FSM: IDLE → (byte==0xA5) HDR → D_HI → D_LO → CHK → IDLE.
  - In IDLE, non-sync bytes are discarded silently.
  - 0xA5 inside a packet is treated as ordinary data.
- Evaluated at the CHK byte. Error priority: checksum (1) > channel (2) > reg (3) > range (4).
- Range rules:
  - waveform payload < 4
  - frequency: 1 ≤ payload < 2^FREQ_W; 0 is rejected
  - amplitude payload < 2^AMP_W
  - offset payload < 2^OFF_W
- Accepted write: shadow[chan] (or all channels) ← payload LSBs; live outputs unchanged; cmd_ok.
- Accepted commit: live ← shadow for all channels; update_stb and cmd_ok.
- Rejected packet: no register changes; cmd_err with err_code.
- Timeout: in a non-IDLE state, if TIMEOUT_CYC consecutive cycles pass without data_valid, go to IDLE with cmd_err, err_code 5. The counter clears on every accepted byte.
- Reset values:
  - live and shadow: waveform 0, frequency 1, amplitude 2^AMP_W−1, offset 2^(OFF_W−1)
  - pulses 0, err_code 0, FSM IDLE, timeout counter 0

## Timing
- Shadow/live writes, cmd_ok, cmd_err and update_stb are registered on the clk edge that samples the CHK byte. They are visible in the following cycle.
- Pulses last exactly one cycle. Back-to-back packets are supported with no dead cycle; the next SYNC may arrive on the cycle after CHK.
- Bytes are accepted only when data_valid is high. Consecutive data_valid cycles are legal.
- data_valid in the cycle the timeout would expire: the byte wins and no timeout occurs.
- Timeout error pulse asserts on the TIMEOUT_CYC-th idle cycle. The FSM is in IDLE in the next cycle, so a SYNC in that cycle starts a new packet.
- rst_n asserted mid-packet: immediate return to reset values; the partial packet is discarded with no error pulse.
- Commit with no pending writes: still pulses update_stb; outputs are unchanged in value.

## Structure
- Package awg_cmd_pkg:
  - SYNC_BYTE
  - reg id constants (REG_WAVE, REG_FREQ, REG_AMP, REG_OFF, REG_COMMIT)
  - CHAN_BCAST
  - err code constants (ERR_NONE 0, ERR_CHK 1, ERR_CHAN 2, ERR_REG 3, ERR_RANGE 4, ERR_TIMEOUT 5)
  - FSM state enum
- Sub-module awg_cmd_regbank:
  - contents: shadow and live arrays per channel, write-enable per channel/field, commit port, reset values
  - parametrised by NUM_CH and the field widths
- The top holds the FSM, byte capture, checksum, validation and timeout counter.

## Test plan
- Reset: check all outputs at reset values (NUM_CH=2: waveform 0, freq 1, amp 0x3FF, off 0x200); no pulses.
- Write then commit:
  - A5 01 12 34 27 → cmd_ok; frequency unchanged.
  - A5 0F 00 00 0F → update_stb; ch0 frequency 0x1234, ch1 still 1.
- Broadcast: A5 F2 00 80 72, then commit → amplitude 0x080 on both channels.
- Errors:
  - A5 01 12 34 00 → err_code 1
  - A5 21 00 05 24 → err_code 2
  - A5 05 00 01 04 → err_code 3
  - A5 02 04 00 06 (amp 0x400) → err_code 4
  - Each case: no shadow change, verified by a subsequent commit.
- Timeout: send A5 03, then TIMEOUT_CYC idle cycles → cmd_err with err_code 5 on the exact cycle. A following full valid packet is accepted.
- Mid-packet reset: assert rst_n low after D_HI, release, then send a valid commit → reset values retained, cmd_ok only for the commit.

Source files
------------

// File: rtl/awg_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : awg_cmd_pkg
// Description : Shared constants, FSM states and helpers for the AWG command
//               decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package awg_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    localparam logic [3:0] REG_WAVE   = 4'h0;
    localparam logic [3:0] REG_FREQ   = 4'h1;
    localparam logic [3:0] REG_AMP    = 4'h2;
    localparam logic [3:0] REG_OFF    = 4'h3;
    localparam logic [3:0] REG_COMMIT = 4'hF;

    localparam logic [3:0] CHAN_BCAST = 4'hF;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CHK     = 3'd1;
    localparam logic [2:0] ERR_CHAN    = 3'd2;
    localparam logic [2:0] ERR_REG     = 3'd3;
    localparam logic [2:0] ERR_RANGE   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CHK  = 3'd4
    } cmd_state_t;

    // True when the 16-bit payload is representable in 'width' bits.
    function automatic logic fits_width(input logic [15:0] value, input int width);
        return (width >= 16) || ((value >> width) == 16'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/awg_cmd_regbank.sv
`default_nettype none
// ============================================================================
// Module      : awg_cmd_regbank
// Description : Per-channel shadow and live waveform parameter registers with
//               a global shadow-to-live commit.
// Revision    : 1.0 - initial release
// ============================================================================
module awg_cmd_regbank #(
    parameter int NUM_CH = 2,
    parameter int FREQ_W = 16,
    parameter int AMP_W  = 10,
    parameter int OFF_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         wr_en,
    input  logic [1:0]                wr_field,
    input  logic [15:0]               wr_data,
    input  logic                      commit,
    output logic [2*NUM_CH-1:0]       waveform_type,
    output logic [FREQ_W*NUM_CH-1:0]  frequency,
    output logic [AMP_W*NUM_CH-1:0]   amplitude,
    output logic [OFF_W*NUM_CH-1:0]   dc_offset
);

    localparam logic [FREQ_W-1:0] c_freq_rst = FREQ_W'(1);
    localparam logic [AMP_W-1:0]  c_amp_rst  = {AMP_W{1'b1}};
    localparam logic [OFF_W-1:0]  c_off_rst  = OFF_W'(1) << (OFF_W - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]        r_sh_wave, r_lv_wave;
        logic [FREQ_W-1:0] r_sh_freq, r_lv_freq;
        logic [AMP_W-1:0]  r_sh_amp,  r_lv_amp;
        logic [OFF_W-1:0]  r_sh_off,  r_lv_off;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sh_wave <= 2'd0;
                r_sh_freq <= c_freq_rst;
                r_sh_amp  <= c_amp_rst;
                r_sh_off  <= c_off_rst;
                r_lv_wave <= 2'd0;
                r_lv_freq <= c_freq_rst;
                r_lv_amp  <= c_amp_rst;
                r_lv_off  <= c_off_rst;
            end else begin
                if (wr_en[i]) begin
                    case (wr_field)
                        2'd0: r_sh_wave <= wr_data[1:0];
                        2'd1: r_sh_freq <= wr_data[FREQ_W-1:0];
                        2'd2: r_sh_amp  <= wr_data[AMP_W-1:0];
                        2'd3: r_sh_off  <= wr_data[OFF_W-1:0];
                    endcase
                end
                if (commit) begin
                    r_lv_wave <= r_sh_wave;
                    r_lv_freq <= r_sh_freq;
                    r_lv_amp  <= r_sh_amp;
                    r_lv_off  <= r_sh_off;
                end
            end
        end

        assign waveform_type[2*i +: 2]     = r_lv_wave;
        assign frequency[FREQ_W*i +: FREQ_W] = r_lv_freq;
        assign amplitude[AMP_W*i +: AMP_W]   = r_lv_amp;
        assign dc_offset[OFF_W*i +: OFF_W]   = r_lv_off;
    end

endmodule
`default_nettype wire

// File: rtl/awg_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : awg_cmd_decoder
// Description : Framed, checksummed UART command parser driving per-channel
//               AWG shadow/live parameter registers.
// Revision    : 1.0 - initial release
// ============================================================================
module awg_cmd_decoder
    import awg_cmd_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int FREQ_W      = 16,
    parameter int AMP_W       = 10,
    parameter int OFF_W       = 10,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                uart_data,
    input  logic                      data_valid,
    output logic [2*NUM_CH-1:0]       waveform_type,
    output logic [FREQ_W*NUM_CH-1:0]  frequency,
    output logic [AMP_W*NUM_CH-1:0]   amplitude,
    output logic [OFF_W*NUM_CH-1:0]   dc_offset,
    output logic                      update_stb,
    output logic                      cmd_ok,
    output logic                      cmd_err,
    output logic [2:0]                err_code
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYC);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);

    cmd_state_t         r_state, w_state_nxt;
    logic [7:0]         r_hdr, r_dhi, r_dlo;
    logic [7:0]         w_hdr_nxt, w_dhi_nxt, w_dlo_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_cmd_ok, r_cmd_err, r_update_stb;
    logic               w_ok_nxt, w_err_nxt, w_upd_nxt;
    logic [2:0]         r_err_code, w_code_nxt;

    logic [3:0]         w_chan, w_reg;
    logic [15:0]        w_payload;
    logic               w_is_commit, w_chk_bad, w_chan_bad, w_reg_bad, w_range_ok;
    logic [2:0]         w_eval_code;
    logic [NUM_CH-1:0]  w_ch_mask, w_wr_en;
    logic               w_commit;

    // Packet evaluation, meaningful only while the CHK byte is on the bus.
    always_comb begin
        w_chan      = r_hdr[7:4];
        w_reg       = r_hdr[3:0];
        w_payload   = {r_dhi, r_dlo};
        w_is_commit = (w_reg == REG_COMMIT);
        w_chk_bad   = (uart_data != (r_hdr ^ r_dhi ^ r_dlo));
        w_chan_bad  = !w_is_commit && (w_chan != CHAN_BCAST) && (int'(w_chan) >= NUM_CH);
        w_reg_bad   = !(w_reg inside {REG_WAVE, REG_FREQ, REG_AMP, REG_OFF, REG_COMMIT});

        case (w_reg)
            REG_WAVE: w_range_ok = (w_payload < 16'd4);
            REG_FREQ: w_range_ok = (w_payload != 16'd0) && fits_width(w_payload, FREQ_W);
            REG_AMP:  w_range_ok = fits_width(w_payload, AMP_W);
            REG_OFF:  w_range_ok = fits_width(w_payload, OFF_W);
            default:  w_range_ok = 1'b1;
        endcase

        if (w_chk_bad)        w_eval_code = ERR_CHK;
        else if (w_chan_bad)  w_eval_code = ERR_CHAN;
        else if (w_reg_bad)   w_eval_code = ERR_REG;
        else if (!w_range_ok) w_eval_code = ERR_RANGE;
        else                  w_eval_code = ERR_NONE;

        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_mask[i] = (w_chan == CHAN_BCAST) || (int'(w_chan) == i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_nxt   = r_hdr;
        w_dhi_nxt   = r_dhi;
        w_dlo_nxt   = r_dlo;
        w_cnt_nxt   = r_cnt;
        w_ok_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_upd_nxt   = 1'b0;
        w_code_nxt  = r_err_code;
        w_wr_en     = '0;
        w_commit    = 1'b0;

        if (r_state == ST_IDLE) begin
            w_cnt_nxt = '0;
            if (data_valid && (uart_data == SYNC_BYTE)) begin
                w_state_nxt = ST_HDR;
            end
        end else if (data_valid) begin
            w_cnt_nxt = '0;
            case (r_state)
                ST_HDR: begin
                    w_hdr_nxt   = uart_data;
                    w_state_nxt = ST_DHI;
                end
                ST_DHI: begin
                    w_dhi_nxt   = uart_data;
                    w_state_nxt = ST_DLO;
                end
                ST_DLO: begin
                    w_dlo_nxt   = uart_data;
                    w_state_nxt = ST_CHK;
                end
                ST_CHK: begin
                    w_state_nxt = ST_IDLE;
                    if (w_eval_code != ERR_NONE) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = w_eval_code;
                    end else begin
                        w_ok_nxt = 1'b1;
                        if (w_is_commit) begin
                            w_commit  = 1'b1;
                            w_upd_nxt = 1'b1;
                        end else begin
                            w_wr_en = w_ch_mask;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (r_cnt == c_cnt_last) begin
            // A byte in this cycle would have taken the branch above instead.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_TIMEOUT;
        end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hdr        <= '0;
            r_dhi        <= '0;
            r_dlo        <= '0;
            r_cnt        <= '0;
            r_cmd_ok     <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_update_stb <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_hdr        <= w_hdr_nxt;
            r_dhi        <= w_dhi_nxt;
            r_dlo        <= w_dlo_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cmd_ok     <= w_ok_nxt;
            r_cmd_err    <= w_err_nxt;
            r_update_stb <= w_upd_nxt;
            r_err_code   <= w_code_nxt;
        end
    end

    awg_cmd_regbank #(
        .NUM_CH (NUM_CH),
        .FREQ_W (FREQ_W),
        .AMP_W  (AMP_W),
        .OFF_W  (OFF_W)
    ) u_regbank (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (w_wr_en),
        .wr_field      (w_reg[1:0]),
        .wr_data       (w_payload),
        .commit        (w_commit),
        .waveform_type (waveform_type),
        .frequency     (frequency),
        .amplitude     (amplitude),
        .dc_offset     (dc_offset)
    );

    assign cmd_ok     = r_cmd_ok;
    assign cmd_err    = r_cmd_err;
    assign update_stb = r_update_stb;
    assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_awg_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_awg_cmd_decoder
// Description : Directed and randomized checks of awg_cmd_decoder against a
//               packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_awg_cmd_decoder;

    localparam int NUM_CH  = 2;
    localparam int FREQ_W  = 16;
    localparam int AMP_W   = 10;
    localparam int OFF_W   = 10;
    localparam int TIMEOUT = 40;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [7:0]                uart_data;
    logic                      data_valid;
    logic [2*NUM_CH-1:0]       waveform_type;
    logic [FREQ_W*NUM_CH-1:0]  frequency;
    logic [AMP_W*NUM_CH-1:0]   amplitude;
    logic [OFF_W*NUM_CH-1:0]   dc_offset;
    logic                      update_stb, cmd_ok, cmd_err;
    logic [2:0]                err_code;

    int n_tests = 0;
    int n_fail  = 0;

    awg_cmd_decoder #(
        .NUM_CH      (NUM_CH),
        .FREQ_W      (FREQ_W),
        .AMP_W       (AMP_W),
        .OFF_W       (OFF_W),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_data     (uart_data),
        .data_valid    (data_valid),
        .waveform_type (waveform_type),
        .frequency     (frequency),
        .amplitude     (amplitude),
        .dc_offset     (dc_offset),
        .update_stb    (update_stb),
        .cmd_ok        (cmd_ok),
        .cmd_err       (cmd_err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    int         m_sh_w[NUM_CH], m_sh_f[NUM_CH], m_sh_a[NUM_CH], m_sh_o[NUM_CH];
    int         m_lv_w[NUM_CH], m_lv_f[NUM_CH], m_lv_a[NUM_CH], m_lv_o[NUM_CH];
    logic [7:0] m_pkt[$];
    int         m_idle;
    bit         m_ok, m_err, m_upd;
    int         m_code;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_sh_w[c] = 0; m_sh_f[c] = 1; m_sh_a[c] = (1 << AMP_W) - 1; m_sh_o[c] = 1 << (OFF_W - 1);
            m_lv_w[c] = 0; m_lv_f[c] = 1; m_lv_a[c] = (1 << AMP_W) - 1; m_lv_o[c] = 1 << (OFF_W - 1);
        end
        m_pkt.delete();
        m_idle = 0; m_ok = 0; m_err = 0; m_upd = 0; m_code = 0;
    endtask

    task automatic model_eval();
        int chan, rg, pay, code;
        chan = int'(m_pkt[1]) >> 4;
        rg   = int'(m_pkt[1]) & 15;
        pay  = int'(m_pkt[2]) * 256 + int'(m_pkt[3]);
        code = 0;
        if ((m_pkt[1] ^ m_pkt[2] ^ m_pkt[3]) != m_pkt[4]) code = 1;
        else if (rg != 15 && chan != 15 && chan >= NUM_CH) code = 2;
        else if (!(rg <= 3 || rg == 15)) code = 3;
        else if ((rg == 0 && pay >= 4) || (rg == 1 && (pay == 0 || pay >= (1 << FREQ_W))) ||
                 (rg == 2 && pay >= (1 << AMP_W)) || (rg == 3 && pay >= (1 << OFF_W))) code = 4;
        if (code != 0) begin
            m_err = 1; m_code = code;
        end else begin
            m_ok = 1;
            if (rg == 15) begin
                m_upd  = 1;
                m_lv_w = m_sh_w; m_lv_f = m_sh_f; m_lv_a = m_sh_a; m_lv_o = m_sh_o;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (chan == 15 || chan == c) begin
                        case (rg)
                            0: m_sh_w[c] = pay;
                            1: m_sh_f[c] = pay;
                            2: m_sh_a[c] = pay;
                            default: m_sh_o[c] = pay;
                        endcase
                    end
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_ok = 0; m_err = 0; m_upd = 0;
            if (m_pkt.size() == 0) begin
                if (data_valid && uart_data == 8'hA5) begin
                    m_pkt.push_back(uart_data);
                    m_idle = 0;
                end
            end else if (data_valid) begin
                m_pkt.push_back(uart_data);
                m_idle = 0;
                if (m_pkt.size() == 5) begin
                    model_eval();
                    m_pkt.delete();
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_err = 1; m_code = 5; m_idle = 0;
                    m_pkt.delete();
                end
            end
        end
    end

    function automatic logic [63:0] exp_vec(input int sel);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (sel)
                0: v[2*c +: 2]           = 2'(m_lv_w[c]);
                1: v[FREQ_W*c +: FREQ_W] = FREQ_W'(m_lv_f[c]);
                2: v[AMP_W*c +: AMP_W]   = AMP_W'(m_lv_a[c]);
                default: v[OFF_W*c +: OFF_W] = OFF_W'(m_lv_o[c]);
            endcase
        end
        return v;
    endfunction

    always @(negedge clk) begin
        check("waveform_type", 64'(waveform_type), exp_vec(0));
        check("frequency",     64'(frequency),     exp_vec(1));
        check("amplitude",     64'(amplitude),     exp_vec(2));
        check("dc_offset",     64'(dc_offset),     exp_vec(3));
        check("cmd_ok",        64'(cmd_ok),        64'(m_ok));
        check("cmd_err",       64'(cmd_err),       64'(m_err));
        check("update_stb",    64'(update_stb),    64'(m_upd));
        check("err_code",      64'(err_code),      64'(m_code));
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [7:0] b);
        @(negedge clk);
        uart_data  = b;
        data_valid = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            data_valid = 1'b0;
            uart_data  = 8'($urandom);
        end
    endtask

    task automatic pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                       input logic [7:0] b4);
        put(8'hA5); put(b1); put(b2); put(b3); put(b4);
    endtask

    task automatic err_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] b4, input logic [2:0] code);
        pkt(b1, b2, b3, b4);
        gap(1);
        check("err_pulse", 64'(cmd_err), 64'd1);
        check("err_code_lit", 64'(err_code), 64'(code));
    endtask

    initial begin
        logic [7:0] bytes[5];
        logic [3:0] ch, rg;
        logic [15:0] pay;
        int sel;

        rst_n = 1'b0; data_valid = 1'b0; uart_data = 8'h00;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_wave", 64'(waveform_type), 64'd0);
        check("rst_freq", 64'(frequency), {16'd1, 16'd1});
        check("rst_amp",  64'(amplitude), {10'h3FF, 10'h3FF});
        check("rst_off",  64'(dc_offset), {10'h200, 10'h200});
        check("rst_pulses", 64'({update_stb, cmd_ok, cmd_err, err_code}), 64'd0);

        pkt(8'h01, 8'h12, 8'h34, 8'h27); gap(1);
        check("write_ok", 64'(cmd_ok), 64'd1);
        check("write_live_held", 64'(frequency), {16'd1, 16'd1});
        pkt(8'h0F, 8'h00, 8'h00, 8'h0F); gap(1);
        check("commit_stb", 64'(update_stb), 64'd1);
        check("commit_freq", 64'(frequency), {16'd1, 16'h1234});

        pkt(8'hF2, 8'h00, 8'h80, 8'h72); gap(1);
        pkt(8'h0F, 8'h00, 8'h00, 8'h0F); gap(1);
        check("bcast_amp", 64'(amplitude), {10'h080, 10'h080});

        err_pkt(8'h01, 8'h12, 8'h34, 8'h00, 3'd1);
        err_pkt(8'h21, 8'h00, 8'h05, 8'h24, 3'd2);
        err_pkt(8'h05, 8'h00, 8'h01, 8'h04, 3'd3);
        err_pkt(8'h02, 8'h04, 8'h00, 8'h06, 3'd4);
        pkt(8'h0F, 8'h00, 8'h00, 8'h0F); gap(1);
        check("err_no_freq", 64'(frequency), {16'd1, 16'h1234});
        check("err_no_amp",  64'(amplitude), {10'h080, 10'h080});

        // Timeout lands exactly on the TIMEOUT-th idle cycle.
        put(8'hA5); put(8'h03);
        for (int i = 0; i < TIMEOUT; i++) begin
            gap(1);
            check("timeout_early", 64'(cmd_err), 64'd0);
        end
        @(negedge clk);
        check("timeout_pulse", 64'(cmd_err), 64'd1);
        check("timeout_code",  64'(err_code), 64'd5);
        uart_data = 8'hA5; data_valid = 1'b1;
        put(8'h01); put(8'h00); put(8'h07); put(8'h06); gap(1);
        check("after_timeout_ok", 64'(cmd_ok), 64'd1);

        // A byte on the last possible idle cycle keeps the packet alive.
        put(8'hA5); put(8'h03); gap(TIMEOUT - 1);
        put(8'h00); put(8'h05); put(8'h06); gap(1);
        check("byte_wins_ok", 64'(cmd_ok), 64'd1);

        put(8'hA5); put(8'h01); put(8'h12);
        @(negedge clk); data_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        pkt(8'h0F, 8'h00, 8'h00, 8'h0F); gap(1);
        check("midrst_ok",   64'(cmd_ok), 64'd1);
        check("midrst_freq", 64'(frequency), {16'd1, 16'd1});
        check("midrst_code", 64'(err_code), 64'd0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) put(8'($urandom_range(0, 164)));
            if ($urandom_range(0, 9) < 2) ch = 4'($urandom);
            else begin
                sel = $urandom_range(0, 2);
                ch  = (sel == 2) ? 4'hF : 4'(sel);
            end
            sel = $urandom_range(0, 9);
            if (sel <= 3)      rg = 4'(sel);
            else if (sel <= 6) rg = 4'hF;
            else if (sel == 7) rg = 4'($urandom);
            else               rg = 4'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       pay = 16'($urandom_range(0, 5));
                1:       pay = 16'($urandom);
                2:       pay = 16'($urandom_range(1022, 1025));
                default: pay = 16'($urandom_range(0, 1023));
            endcase
            bytes[0] = 8'hA5;
            bytes[1] = {ch, rg};
            bytes[2] = pay[15:8];
            bytes[3] = pay[7:0];
            bytes[4] = bytes[1] ^ bytes[2] ^ bytes[3];
            if ($urandom_range(0, 9) == 0) bytes[4] = bytes[4] ^ 8'($urandom_range(1, 255));
            for (int b = 0; b < 5; b++) begin
                put(bytes[b]);
                if ($urandom_range(0, 49) == 0) gap($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
                else gap($urandom_range(0, 2));
            end
        end
        gap(TIMEOUT + 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
